// File: rtl/neuro_cmd_sequencer_pkg.sv
// Shared protocol constants, error codes and state encoding for the command sequencer.
package neuro_cmd_sequencer_pkg;

  localparam logic [7:0] OP_WR_W    = 8'h01;
  localparam logic [7:0] OP_WR_X    = 8'h02;
  localparam logic [7:0] OP_RUN     = 8'h03;
  localparam logic [7:0] OP_STATUS  = 8'h04;
  localparam logic [7:0] OP_CLR_ERR = 8'h05;

  localparam logic [7:0] ERR_OPCODE  = 8'hEE;
  localparam logic [7:0] ERR_RANGE   = 8'hEA;
  localparam logic [7:0] ERR_TIMEOUT = 8'hE7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RUN_START = 3'd4,
    ST_RUN_WAIT  = 3'd5
  } state_t;

  // Status reply: sticky error bit, then the state the sequencer is in when asked.
  function automatic logic [7:0] status_byte(input logic err_flag, input state_t st);
    return {err_flag, st, 4'b0000};
  endfunction

endpackage

// File: rtl/neuro_timeout_ctr.sv
// Inter-byte idle counter; tc is high in the cycle the count reaches TIMEOUT-1 while enabled.
module neuro_timeout_ctr #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [23:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 24'd1;
    end
  end

  assign tc = en && (cnt == (TIMEOUT - 24'd1));

endmodule

// File: rtl/neuro_cmd_sequencer.sv
// Host byte-protocol parser driving weight/input writes and compute runs; results/status on logs.
// Optional NEUROCORE_ECHO_EN: echo every received byte on logs (result/status/error codes win).
module neuro_cmd_sequencer
  import neuro_cmd_sequencer_pkg::*;
#(
  parameter int          ADDR_W  = 4,
  parameter int          NUM_W   = 16,
  parameter int          NUM_X   = 4,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start,
  input  logic              done,
  input  logic [7:0]        result,
  output logic [7:0]        logs,
  output logic              err
);

  localparam logic [8:0] W_LIM = 9'(NUM_W);
  localparam logic [8:0] X_LIM = 9'(NUM_X);

  state_t     state;
  logic [7:0] addr_byte;
  logic       addr_ok;
  logic       tmo_en;
  logic       tmo_clr;
  logic       tmo_tc;

  // Range check uses the full address byte so aliasing high bits cannot sneak past.
  assign addr_ok = wr_sel ? ({1'b0, addr_byte} < X_LIM) : ({1'b0, addr_byte} < W_LIM);

  assign tmo_en  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  assign tmo_clr = rx_valid || !tmo_en;

  neuro_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      addr_byte <= 8'h00;
      start     <= 1'b0;
      logs      <= 8'h00;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      start <= 1'b0;
`ifdef NEUROCORE_ECHO_EN
      // Later writes to logs in this block override the echo.
      if (rx_valid) logs <= rx_data;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OP_WR_W, OP_WR_X: begin
                wr_sel <= (rx_data == OP_WR_X);
                state  <= ST_GET_ADDR;
              end
              OP_RUN: begin
                start <= 1'b1;
                state <= ST_RUN_START;
              end
              OP_STATUS:  logs <= status_byte(err, state);
              OP_CLR_ERR: err  <= 1'b0;
              default: begin
                err  <= 1'b1;
                logs <= ERR_OPCODE;
              end
            endcase
          end
        end
        ST_GET_ADDR: begin
          if (rx_valid) begin
            addr_byte <= rx_data;
            wr_addr   <= rx_data[ADDR_W-1:0];
            state     <= ST_GET_DATA;
          end else if (tmo_tc) begin
            err   <= 1'b1;
            logs  <= ERR_TIMEOUT;
            state <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (rx_valid) begin
            if (addr_ok) begin
              wr_data <= rx_data;
              wr_en   <= 1'b1;
              state   <= ST_WRITE;
            end else begin
              err   <= 1'b1;
              logs  <= ERR_RANGE;
              state <= ST_IDLE;
            end
          end else if (tmo_tc) begin
            err   <= 1'b1;
            logs  <= ERR_TIMEOUT;
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (rx_valid) err <= 1'b1;
          state <= ST_IDLE;
        end
        ST_RUN_START: begin
          if (rx_valid) err <= 1'b1;
          state <= ST_RUN_WAIT;
        end
        ST_RUN_WAIT: begin
          if (rx_valid) err <= 1'b1;
          if (done) begin
            logs  <= result;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuro_cmd_sequencer.sv
// Scoreboard bench: transaction-level model queues expected events, negedge monitor pops and compares.
module tb_neuro_cmd_sequencer;

  localparam int TMO   = 100;
  localparam int NUMW  = 16;
  localparam int NUMX  = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       done = 1'b0;
  logic [7:0] result = 8'h00;
  logic       wr_en, wr_sel, start, err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, logs;

  neuro_cmd_sequencer #(
    .ADDR_W (4), .NUM_W (NUMW), .NUM_X (NUMX), .TIMEOUT (24'd100)
  ) dut (
    .CLK (CLK), .RESET (RESET), .rx_valid (rx_valid), .rx_data (rx_data),
    .wr_en (wr_en), .wr_sel (wr_sel), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start), .done (done), .result (result), .logs (logs), .err (err)
  );

  always #5 CLK = ~CLK;

  typedef struct { int cyc; logic sel; logic [3:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { int cyc; logic [7:0] val; } byte_exp_t;

  wr_exp_t   wq[$];
  int        sq[$];
  byte_exp_t lq[$];
  byte_exp_t eq[$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  task automatic check(input string name, input bit ok, input string detail);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: collects command bytes into a buffer and acts on complete commands.
  localparam int P_IDLE = 0, P_COLLECT = 1, P_WRITING = 2, P_STARTING = 3, P_WAITING = 4;
  int         phase = P_IDLE;
  logic [7:0] cmd[$];
  int         silent = 0;
  logic [7:0] m_logs = 8'h00;
  logic       m_err = 1'b0;

  task automatic model_reset();
    phase = P_IDLE; cmd.delete(); silent = 0;
    m_logs = 8'h00; m_err = 1'b0;
    wq.delete(); sq.delete(); lq.delete(); eq.delete();
  endtask

  task automatic model_step();
    logic [7:0] nl;
    logic       ne;
    int         limit;
    logic [7:0] a;
    wr_exp_t    w;
    byte_exp_t  be;
    nl = m_logs;
    ne = m_err;
`ifdef NEUROCORE_ECHO_EN
    if (rx_valid) nl = rx_data;
`endif
    case (phase)
      P_IDLE: if (rx_valid) begin
        if (rx_data == 8'h01 || rx_data == 8'h02) begin
          cmd.delete(); cmd.push_back(rx_data); silent = 0; phase = P_COLLECT;
        end else if (rx_data == 8'h03) begin
          sq.push_back(cyc); phase = P_STARTING;
        end else if (rx_data == 8'h04) nl = {m_err, 7'd0};
        else if (rx_data == 8'h05) ne = 1'b0;
        else begin ne = 1'b1; nl = 8'hEE; end
      end
      P_COLLECT: begin
        if (rx_valid) begin
          cmd.push_back(rx_data); silent = 0;
          if (cmd.size() == 3) begin
            limit = (cmd[0] == 8'h01) ? NUMW : NUMX;
            a = cmd[1];
            if (int'(a) < limit) begin
              w.cyc = cyc; w.sel = (cmd[0] == 8'h02); w.addr = a[3:0]; w.data = cmd[2];
              wq.push_back(w); phase = P_WRITING;
            end else begin
              ne = 1'b1; nl = 8'hEA; phase = P_IDLE;
            end
          end
        end else begin
          silent++;
          if (silent == TMO) begin ne = 1'b1; nl = 8'hE7; phase = P_IDLE; end
        end
      end
      P_WRITING:  begin if (rx_valid) ne = 1'b1; phase = P_IDLE; end
      P_STARTING: begin if (rx_valid) ne = 1'b1; phase = P_WAITING; end
      P_WAITING: begin
        if (rx_valid) ne = 1'b1;
        if (done) begin nl = result; phase = P_IDLE; end
      end
      default: phase = P_IDLE;
    endcase
    if (nl != m_logs) begin be.cyc = cyc; be.val = nl; lq.push_back(be); end
    if (ne != m_err) begin be.cyc = cyc; be.val = {7'd0, ne}; eq.push_back(be); end
    m_logs = nl;
    m_err = ne;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RESET) model_reset();
      else model_step();
    end
  end

  // Monitor
  logic [7:0] prev_logs = 8'h00;
  logic       prev_err = 1'b0;

  initial begin
    wr_exp_t   w;
    byte_exp_t b;
    int        s;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        check("reset_vals", !wr_en && !start && !wr_sel && wr_addr == 4'd0 && wr_data == 8'h00
              && logs == 8'h00 && !err,
              $sformatf("wr_en=%0b start=%0b sel=%0b addr=%0h data=%02h logs=%02h err=%0b, required all zero",
                        wr_en, start, wr_sel, wr_addr, wr_data, logs, err));
        prev_logs = 8'h00;
        prev_err = 1'b0;
      end else begin
        if (wr_en) begin
          if (wq.size() == 0) check("wr_unexpected", 1'b0, $sformatf("wr_en at cycle %0d, required none", cyc));
          else begin
            w = wq.pop_front();
            check("wr", w.cyc == cyc && w.sel == wr_sel && w.addr == wr_addr && w.data == wr_data,
                  $sformatf("cyc=%0d sel=%0b addr=%0h data=%02h, required cyc=%0d sel=%0b addr=%0h data=%02h",
                            cyc, wr_sel, wr_addr, wr_data, w.cyc, w.sel, w.addr, w.data));
          end
        end
        if (start) begin
          if (sq.size() == 0) check("start_unexpected", 1'b0, $sformatf("start at cycle %0d, required none", cyc));
          else begin
            s = sq.pop_front();
            check("start", s == cyc, $sformatf("start at cycle %0d, required %0d", cyc, s));
          end
        end
        if (logs != prev_logs) begin
          if (lq.size() == 0) check("logs_unexpected", 1'b0, $sformatf("logs=%02h at cycle %0d, required unchanged %02h", logs, cyc, prev_logs));
          else begin
            b = lq.pop_front();
            check("logs", b.cyc == cyc && b.val == logs,
                  $sformatf("logs=%02h at cycle %0d, required %02h at cycle %0d", logs, cyc, b.val, b.cyc));
          end
        end
        if (err != prev_err) begin
          if (eq.size() == 0) check("err_unexpected", 1'b0, $sformatf("err=%0b at cycle %0d, required unchanged", err, cyc));
          else begin
            b = eq.pop_front();
            check("err", b.cyc == cyc && b.val[0] == err,
                  $sformatf("err=%0b at cycle %0d, required %0b at cycle %0d", err, cyc, b.val[0], b.cyc));
          end
        end
        prev_logs = logs;
        prev_err = err;
      end
    end
  end

  // Stimulus
  task automatic tick(input bit v, input logic [7:0] b, input bit d, input logic [7:0] r);
    @(negedge CLK);
    rx_valid = v; rx_data = b; done = d; result = r;
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    rx_valid = 1'b0; done = 1'b0;
    #2 RESET = 1'b0;
    repeat (n) @(negedge CLK);
    #2 RESET = 1'b1;
  endtask

  initial begin
    int r;
    int k;
    logic [7:0] b;
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b1;
    idle(2);

    send(8'h01); send(8'h03); send(8'h5A); idle(3);
    send(8'h02); send(8'h07); send(8'h11); idle(2); send(8'h05); idle(2);
    send(8'h03); idle(3); send(8'h10); idle(15);
    tick(1'b0, 8'h00, 1'b1, 8'h42); idle(3); send(8'h05); idle(2);
    tick(1'b0, 8'h00, 1'b1, 8'h77); idle(2);
    send(8'h01); idle(110); send(8'h01); send(8'h00); send(8'hFF); idle(3);
    send(8'h01); idle(TMO - 1); send(8'h02); idle(TMO - 1); send(8'h44); idle(3);
    send(8'h99); idle(1); send(8'h04); idle(2);
    send(8'h05); idle(1); send(8'h01); send(8'h02); idle(2);
    do_reset(3); idle(5); send(8'h04); idle(3);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 300) begin
        k = $urandom_range(0, 9);
        if (k < 5) b = 8'($urandom_range(1, 5));
        else if (k < 8) b = 8'($urandom_range(0, 19));
        else b = 8'($urandom_range(0, 255));
        tick(1'b1, b, ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
      end else if (r < 980) begin
        tick(1'b0, 8'h00, ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
      end else if (r < 997) begin
        idle($urandom_range(TMO - 5, TMO + 20));
      end else begin
        do_reset($urandom_range(1, 3));
      end
    end
    idle(6);

    check("wq_drained", wq.size() == 0, $sformatf("%0d writes pending, required 0", wq.size()));
    check("sq_drained", sq.size() == 0, $sformatf("%0d starts pending, required 0", sq.size()));
    check("lq_drained", lq.size() == 0, $sformatf("%0d logs updates pending, required 0", lq.size()));
    check("eq_drained", eq.size() == 0, $sformatf("%0d err updates pending, required 0", eq.size()));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/neuro_cmd_sequencer.md
Name: neuro_cmd_sequencer

Overview:
- Command sequencer between the UART byte receiver and the neuron compute core.
- Parses a byte-oriented host protocol (opcode + payload) into weight/input memory writes and compute runs.
- Runs the start/done handshake with the core and publishes results and status on the 8-bit logs bus.
- Sits inside NeuralChip, downstream of the RX deserializer, upstream of weight/input storage and the compute engine.

Parameters:
- ADDR_W, 4, width of weight/input memory address (16 entries).
- NUM_W, 16, number of valid weight addresses; addr >= NUM_W is rejected.
- NUM_X, 4, number of valid input addresses; addr >= NUM_X is rejected.
- TIMEOUT, 24'd10_000_000, idle cycles allowed between payload bytes before the command is aborted.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-low (0 = reset).
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- wr_en  out  1  one-cycle memory write strobe.
- wr_sel  out  1  0 = weight memory, 1 = input memory.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8  write data.
- start  out  1  one-cycle compute start pulse.
- done  in  1  one-cycle compute completion pulse.
- result  in  8  compute result; valid in the cycle done is high.
- logs  out  8  result/status byte to host.
- err  out  1  sticky error flag; cleared by the CLR_ERR command.

Behaviour:
- Reset (async assert, sync release): state = IDLE; wr_en, start, err = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; logs = 0x00; timeout counter = 0.
- Opcodes:
  - 0x01 WR_W: addr, data.
  - 0x02 WR_X: addr, data.
  - 0x03 RUN: no payload.
  - 0x04 STATUS: no payload.
  - 0x05 CLR_ERR: no payload.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, RUN_START, RUN_WAIT.
- IDLE, on rx_valid:
  - 0x01/0x02: latch wr_sel, go to GET_ADDR.
  - 0x03: go to RUN_START.
  - 0x04: logs <= {err, state_code[2:0], 4'b0}, where state_code is the current state encoding.
  - 0x05: err <= 0.
  - Any other byte: err <= 1, logs <= 0xEE, stay in IDLE.
- GET_ADDR, on rx_valid: latch addr into wr_addr, go to GET_DATA.
- GET_DATA, on rx_valid:
  - In range (addr < NUM_W for weights, addr < NUM_X for inputs): latch wr_data, go to WRITE.
  - Out of range: err <= 1, logs <= 0xEA, go to IDLE, no write.
- WRITE: wr_en = 1 for exactly one cycle, then IDLE. Latency from the data-byte strobe to wr_en is 1 cycle.
- RUN_START: start = 1 for exactly one cycle, then RUN_WAIT.
- RUN_WAIT, on done: logs <= result, go to IDLE. No timeout applies in this state.
- rx_valid in WRITE, RUN_START or RUN_WAIT: byte dropped, err <= 1.
- Timeout:
  - Counter runs only in GET_ADDR and GET_DATA; cleared on each rx_valid and on state entry.
  - At TIMEOUT-1: err <= 1, logs <= 0xE7, go to IDLE.
- Simultaneous timeout terminal count and rx_valid: the byte wins, no timeout.
- done outside RUN_WAIT: ignored, logs unchanged.
- Reset mid-command: state abandoned; no wr_en or start is emitted after RESET rises.
- Outputs are registered; logs holds its value until overwritten.

Optional Feature:
- Macro NEUROCORE_ECHO_EN.
- Defined: every accepted rx_valid byte is copied to logs one cycle after the strobe, in every state. Result and error writes to logs in the same cycle take priority over the echo.
- Undefined: logs changes only on result, STATUS, or an error code.

Decomposition:
- Shared defines file define.v holds:
  - opcode constants: OP_WR_W, OP_WR_X, OP_RUN, OP_STATUS, OP_CLR_ERR;
  - error codes: 0xEE, 0xEA, 0xE7;
  - state encodings (3-bit).
- One sub-module, neuro_timeout_ctr: 24-bit counter with clear/enable inputs and a terminal-count output, parameterised by TIMEOUT.

Test Plan:
- Bytes 01,03,5A -> wr_en one cycle, wr_sel=0, wr_addr=3, wr_data=0x5A; err=0.
- Bytes 02,07,11 (NUM_X=4) -> no wr_en; err=1; logs=0xEA. Then 05 -> err=0.
- Byte 03 -> start pulses once. Drive done with result=0x42 after 20 cycles -> logs=0x42, back to IDLE. An rx byte sent during the wait sets err=1.
- Byte 01, then silence (TIMEOUT overridden to 100) -> after 100 cycles logs=0xE7, err=1. The next 01,00,FF writes correctly.
- Byte 0x99 -> logs=0xEE, err=1. Then 04 -> logs=0x80.
- Assert RESET low between addr and data bytes -> all outputs at reset values; no wr_en after release. With NEUROCORE_ECHO_EN, byte 01 appears on logs one cycle after rx_valid.
